// File: rtl/sprite_scanner.sv
// Per-line OAM scanner: walks all OAM entries, selects up to N_SLOTS objects on the
// current line and feeds them to the sprite store. Optional macro SPRITE_SCAN_OVF_EN adds scan_ovf.
module sprite_scanner #(
    parameter int N_ENTRIES     = 40,
    parameter int N_SLOTS       = 10,
    parameter int CYC_PER_ENTRY = 2
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               scan_start,
    input  logic [7:0]         ly,
    input  logic               obj_tall,
    input  logic [7:0]         oam_rd_y,
    output logic [5:0]         oam_a,
    output logic               oam_rd,
    output logic               store_clr,
    output logic [N_SLOTS-1:0] store_wr,
    output logic [5:0]         store_idx,
    output logic [3:0]         store_line,
    output logic               scan_busy,
    output logic               scan_done,
    output logic [3:0]         hit_count
`ifdef SPRITE_SCAN_OVF_EN
    ,
    output logic               scan_ovf
`endif
);

    typedef enum logic [1:0] {IDLE, ADDR, CMP, DONE} state_t;

    state_t             state_reg;
    logic [5:0]         entry_reg;
    logic [3:0]         hit_count_reg;
    logic [8:0]         diff;
    logic               hit;
    logic               slot_free;
    logic [N_SLOTS-1:0] slot_onehot;

    // The FSM hard-codes one address cycle plus one compare cycle per entry.
    generate
        if (CYC_PER_ENTRY != 2) begin : g_bad_cfg
            $error("sprite_scanner supports CYC_PER_ENTRY == 2 only");
        end
    endgenerate

    // Offset by 16 so sprites partially above the screen still match; negatives wrap high.
    assign diff      = {1'b0, ly} + 9'd16 - {1'b0, oam_rd_y};
    assign hit       = diff < (obj_tall ? 9'd16 : 9'd8);
    assign slot_free = hit_count_reg < 4'(N_SLOTS);
    assign hit_count = hit_count_reg;

    generate
        for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot_sel
            assign slot_onehot[gi] = (hit_count_reg == 4'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_reg     <= IDLE;
            entry_reg     <= '0;
            hit_count_reg <= '0;
            oam_a         <= '0;
            oam_rd        <= 1'b0;
            store_clr     <= 1'b0;
            store_wr      <= '0;
            store_idx     <= '0;
            store_line    <= '0;
            scan_busy     <= 1'b0;
            scan_done     <= 1'b0;
`ifdef SPRITE_SCAN_OVF_EN
            scan_ovf      <= 1'b0;
`endif
        end else begin
            store_clr  <= 1'b0;
            store_wr   <= '0;
            store_idx  <= '0;
            store_line <= '0;
            scan_done  <= 1'b0;
            oam_rd     <= 1'b0;
            // A new start always wins, which also drops any write from an in-flight compare.
            if (scan_start) begin
                state_reg     <= ADDR;
                entry_reg     <= '0;
                hit_count_reg <= '0;
                oam_a         <= '0;
                oam_rd        <= 1'b1;
                store_clr     <= 1'b1;
                scan_busy     <= 1'b1;
`ifdef SPRITE_SCAN_OVF_EN
                scan_ovf      <= 1'b0;
`endif
            end else begin
                case (state_reg)
                    ADDR: state_reg <= CMP;
                    CMP: begin
                        if (hit && slot_free) begin
                            store_wr      <= slot_onehot;
                            store_idx     <= entry_reg;
                            store_line    <= diff[3:0];
                            hit_count_reg <= hit_count_reg + 4'd1;
                        end
`ifdef SPRITE_SCAN_OVF_EN
                        if (hit && !slot_free) begin
                            scan_ovf <= 1'b1;
                        end
`endif
                        if (entry_reg == 6'(N_ENTRIES - 1)) begin
                            state_reg <= DONE;
                            scan_busy <= 1'b0;
                            scan_done <= 1'b1;
                        end else begin
                            state_reg <= ADDR;
                            entry_reg <= entry_reg + 6'd1;
                            oam_a     <= entry_reg + 6'd1;
                            oam_rd    <= 1'b1;
                        end
                    end
                    DONE:    state_reg <= IDLE;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_scanner.sv
// Directed bench for sprite_scanner: OAM Y-byte model, per-scan write capture, hand-computed expectations.
module tb_sprite_scanner;

    localparam int N_SLOTS = 10;

    logic               clk = 1'b0;
    logic               nreset = 1'b0;
    logic               scan_start = 1'b0;
    logic [7:0]         ly = 8'd0;
    logic               obj_tall = 1'b0;
    logic [7:0]         oam_rd_y = 8'd0;
    logic [5:0]         oam_a;
    logic               oam_rd;
    logic               store_clr;
    logic [N_SLOTS-1:0] store_wr;
    logic [5:0]         store_idx;
    logic [3:0]         store_line;
    logic               scan_busy;
    logic               scan_done;
    logic [3:0]         hit_count;
`ifdef SPRITE_SCAN_OVF_EN
    logic               scan_ovf;
`endif

    logic [7:0] oam_y [64];
    int n_tests = 0;
    int n_fail  = 0;
    int wr_n;
    int done_cyc;
    int wr_raw  [16];
    int wr_idx  [16];
    int wr_line [16];

    sprite_scanner dut (
        .clk        (clk),
        .nreset     (nreset),
        .scan_start (scan_start),
        .ly         (ly),
        .obj_tall   (obj_tall),
        .oam_rd_y   (oam_rd_y),
        .oam_a      (oam_a),
        .oam_rd     (oam_rd),
        .store_clr  (store_clr),
        .store_wr   (store_wr),
        .store_idx  (store_idx),
        .store_line (store_line),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done),
        .hit_count  (hit_count)
`ifdef SPRITE_SCAN_OVF_EN
        ,
        .scan_ovf   (scan_ovf)
`endif
    );

    always #5 clk = ~clk;

    // OAM returns the Y byte one cycle after the address is presented.
    always @(posedge clk) begin
        if (oam_rd) oam_rd_y <= oam_y[oam_a];
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_oam(input logic [7:0] y);
        for (int i = 0; i < 64; i++) oam_y[i] = y;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_oam_a"}, oam_a, 0);
        check({tag, "_oam_rd"}, oam_rd, 0);
        check({tag, "_clr"}, store_clr, 0);
        check({tag, "_wr"}, store_wr, 0);
        check({tag, "_idx"}, store_idx, 0);
        check({tag, "_line"}, store_line, 0);
        check({tag, "_busy"}, scan_busy, 0);
        check({tag, "_done"}, scan_done, 0);
        check({tag, "_hits"}, hit_count, 0);
    endtask

    // Cycle 1 = first cycle after the edge that samples scan_start (first ADDR).
    task automatic run_scan(input int restart_cyc, input int reset_cyc);
        int cyc;
        bit restarted;
        restarted = 0;
        wr_n = 0;
        done_cyc = 0;
        @(negedge clk); scan_start = 1'b1;
        @(negedge clk); scan_start = 1'b0;
        cyc = 1;
        check("start_clr", store_clr, 1);
        check("start_busy", scan_busy, 1);
        check("start_oam_a", oam_a, 0);
        check("start_oam_rd", oam_rd, 1);
        while (cyc < 200) begin
            if (store_wr != 0 && wr_n < 16) begin
                wr_raw[wr_n]  = int'(store_wr);
                wr_idx[wr_n]  = int'(store_idx);
                wr_line[wr_n] = int'(store_line);
                wr_n++;
            end
            if (scan_done) begin
                done_cyc = cyc;
                break;
            end
            if (!restarted && cyc == restart_cyc) begin
                restarted = 1;
                check("restart_at_oam_a", oam_a, 20);
                scan_start = 1'b1;
                @(negedge clk); scan_start = 1'b0;
                cyc = 1;
                wr_n = 0;
                check("restart_clr", store_clr, 1);
                check("restart_hits", hit_count, 0);
                check("restart_oam_a", oam_a, 0);
                check("restart_wr", store_wr, 0);
                continue;
            end
            if (cyc == reset_cyc) begin
                check("rst_at_oam_a", oam_a, 15);
                nreset = 1'b0;
                @(negedge clk);
                check_all_zero("midrst");
                nreset = 1'b1;
                repeat (3) @(negedge clk);
                check("midrst_idle_busy", scan_busy, 0);
                check("midrst_idle_rd", oam_rd, 0);
                return;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic finish_scan(input string tag, input int exp_hits);
        check({tag, "_done_cyc"}, done_cyc, 81);
        check({tag, "_busy_low"}, scan_busy, 0);
        check({tag, "_hit_count"}, hit_count, exp_hits);
        check({tag, "_wr_n"}, wr_n, exp_hits);
        @(negedge clk);
        check({tag, "_done_pulse"}, scan_done, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        nreset = 1'b1;
        @(negedge clk);

        // 1: single hit at entry 5, line 0
        fill_oam(8'd0); oam_y[5] = 8'd16; ly = 8'd0; obj_tall = 1'b0;
        run_scan(0, 0);
        check("t1_slot", wr_raw[0], 1);
        check("t1_idx", wr_idx[0], 5);
        check("t1_line", wr_line[0], 0);
        finish_scan("t1", 1);
`ifdef SPRITE_SCAN_OVF_EN
        check("t1_ovf", scan_ovf, 0);
`endif

        // 2: every entry hits in 8x16 mode; only the first ten are stored
        fill_oam(8'd30); ly = 8'd20; obj_tall = 1'b1;
        run_scan(0, 0);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("t2_slot%0d", k), wr_raw[k], 1 << k);
            check($sformatf("t2_idx%0d", k), wr_idx[k], k);
            check($sformatf("t2_line%0d", k), wr_line[k], 6);
        end
        finish_scan("t2", 10);
`ifdef SPRITE_SCAN_OVF_EN
        check("t2_ovf", scan_ovf, 1);
`endif

        // 3: boundaries at ly=10, 8x8 then 8x16
        fill_oam(8'd200);
        oam_y[0] = 8'd19; oam_y[1] = 8'd18; oam_y[2] = 8'd26; oam_y[3] = 8'd27;
        ly = 8'd10; obj_tall = 1'b0;
        run_scan(0, 0);
        check("t3s_idx0", wr_idx[0], 0);
        check("t3s_line0", wr_line[0], 7);
        check("t3s_slot1", wr_raw[1], 2);
        check("t3s_idx1", wr_idx[1], 2);
        check("t3s_line1", wr_line[1], 0);
        finish_scan("t3s", 2);
        obj_tall = 1'b1;
        run_scan(0, 0);
        check("t3t_line0", wr_line[0], 7);
        check("t3t_idx1", wr_idx[1], 1);
        check("t3t_line1", wr_line[1], 8);
        check("t3t_idx2", wr_idx[2], 2);
        check("t3t_line2", wr_line[2], 0);
        finish_scan("t3t", 3);

        // 4: restart during entry 20's address cycle
        fill_oam(8'd30); ly = 8'd20; obj_tall = 1'b1;
        run_scan(41, 0);
        check("t4_first_idx", wr_idx[0], 0);
        check("t4_last_idx", wr_idx[9], 9);
        finish_scan("t4", 10);

        // 5: reset during entry 15, then a normal scan
        run_scan(0, 31);
        fill_oam(8'd0); oam_y[5] = 8'd16; ly = 8'd0; obj_tall = 1'b0;
        run_scan(0, 0);
        check("t5_idx", wr_idx[0], 5);
        finish_scan("t5", 1);

        // 6: wrap-around and exact-16 misses
        fill_oam(8'd0); oam_y[0] = 8'd255; ly = 8'd0; obj_tall = 1'b1;
        run_scan(0, 0);
        finish_scan("t6", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
